// File: rtl/memory_request_master_if.sv
// Client command/response and memory_unit handshake bundle for memory_request_master.
// The master modport is the requester's view; slave is the client and memory side.
interface memory_request_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;

  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;

  logic [1:0]        mem_func;
  logic              mem_execute;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_is_ready;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_addr, rsp_data, rsp_error,
    output mem_func, mem_execute, mem_addr_in, mem_data_in,
    input  mem_is_ready, mem_addr_out, mem_data_out
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_addr, rsp_data, rsp_error,
    input  mem_func, mem_execute, mem_addr_in, mem_data_in,
    output mem_is_ready, mem_addr_out, mem_data_out
  );
endinterface

// File: rtl/memory_request_master.sv
// Initiator for the memory_unit func/execute/is_ready protocol: one client command
// at a time, CONS as GET_FREE followed by SET_CONTENTS, watchdog on every memory wait.
module memory_request_master #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     power,
  memory_request_master_if.master bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CONS  = 2'd2;

  localparam logic [1:0] GET_CONTENTS = 2'd0;
  localparam logic [1:0] SET_CONTENTS = 2'd1;
  localparam logic [1:0] GET_FREE     = 2'd2;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              resync_q, resync_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic [1:0]        mem_func_q, mem_func_d;
  logic              mem_execute_q, mem_execute_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;

  logic accept;
  assign accept = bus.cmd_valid & cmd_ready_q;

  // State and output registers; power low freezes everything, reset overrides power.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      resync_q      <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      wd_q          <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      mem_func_q    <= 2'd0;
      mem_execute_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
    end else if (power) begin
      state_q       <= state_d;
      resync_q      <= resync_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wd_q          <= wd_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      mem_func_q    <= mem_func_d;
      mem_execute_q <= mem_execute_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
    end
  end

  // Next-state and next-output logic; execute and rsp_valid are single-cycle pulses.
  always_comb begin
    state_d       = state_q;
    resync_d      = resync_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wd_d          = wd_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_addr_d    = rsp_addr_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    mem_func_d    = mem_func_q;
    mem_execute_d = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;

    unique case (state_q)
      S_BOOT: begin
        if (bus.mem_is_ready) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          resync_d    = 1'b0;
        end
      end

      S_IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          addr_d      = bus.cmd_addr;
          data_d      = bus.cmd_data;
          rsp_error_d = 1'b0;
          mem_addr_d  = bus.cmd_addr;
          mem_data_d  = bus.cmd_data;
          unique case (bus.cmd_op)
            OP_READ: begin
              mem_func_d    = GET_CONTENTS;
              mem_execute_d = 1'b1;
              state_d       = S_ISSUE;
            end
            OP_WRITE: begin
              mem_func_d    = SET_CONTENTS;
              mem_execute_d = 1'b1;
              state_d       = S_ISSUE;
            end
            OP_CONS: begin
              mem_func_d    = GET_FREE;
              mem_execute_d = 1'b1;
              state_d       = S_ISSUE;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_error_d = 1'b1;
              rsp_addr_d  = bus.cmd_addr;
              rsp_data_d  = '0;
              state_d     = S_RESP;
            end
          endcase
        end
      end

      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.mem_is_ready) begin
          unique case (mem_func_q)
            GET_CONTENTS: begin
              rsp_valid_d = 1'b1;
              rsp_addr_d  = addr_q;
              rsp_data_d  = bus.mem_data_out;
              state_d     = S_RESP;
            end
            SET_CONTENTS: begin
              rsp_valid_d = 1'b1;
              rsp_addr_d  = addr_q;
              rsp_data_d  = '0;
              state_d     = S_RESP;
            end
            GET_FREE: begin
              // Allocated cell becomes the target of the follow-up write.
              addr_d        = bus.mem_addr_out;
              mem_addr_d    = bus.mem_addr_out;
              mem_data_d    = data_q;
              mem_func_d    = SET_CONTENTS;
              mem_execute_d = 1'b1;
              state_d       = S_ISSUE;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_error_d = 1'b1;
              rsp_addr_d  = addr_q;
              rsp_data_d  = '0;
              state_d     = S_RESP;
            end
          endcase
        end else if (wd_q == WD_LAST) begin
          // Memory presumed lost; report and re-wait for is_ready before new work.
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_data_d  = '0;
          resync_d    = 1'b1;
          state_d     = S_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_RESP: begin
        state_d     = resync_q ? S_BOOT : S_IDLE;
        cmd_ready_d = ~resync_q;
      end

      default: begin
        state_d     = S_BOOT;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.mem_func    = mem_func_q;
  assign bus.mem_execute = mem_execute_q;
  assign bus.mem_addr_in = mem_addr_q;
  assign bus.mem_data_in = mem_data_q;

endmodule

// File: tb/tb_memory_request_master.sv
// Bench for memory_request_master: behavioural memory_unit stand-in plus a response
// scoreboard filled when commands are issued and drained when rsp_valid pulses.
`timescale 1ns/1ps
module tb_memory_request_master;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned BOOT_LAT = 6;
  localparam int unsigned MEM_LAT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic power = 1'b1;
  always #5 clk = ~clk;

  memory_request_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_request_master #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .power (power),
    .bus   (bus)
  );

  // Memory stand-in: init delay after reset, fixed op latency, optional stuck busy.
  logic [DATA_W-1:0] mem_store [0:255];
  logic [ADDR_W-1:0] free_ptr = 16'h0010;
  int                boot_cnt;
  int                busy;
  logic [1:0]        p_func;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  bit                stuck = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      bus.mem_is_ready <= 1'b0;
      boot_cnt         <= BOOT_LAT;
      busy             <= 0;
    end else if (power) begin
      if (boot_cnt > 0) begin
        boot_cnt <= boot_cnt - 1;
        if (boot_cnt == 1) bus.mem_is_ready <= 1'b1;
      end else if (bus.mem_execute) begin
        bus.mem_is_ready <= 1'b0;
        busy             <= MEM_LAT;
        p_func           <= bus.mem_func;
        p_addr           <= bus.mem_addr_in;
        p_data           <= bus.mem_data_in;
      end else if (busy > 1) begin
        busy <= busy - 1;
      end else if (busy == 1 && !stuck) begin
        case (p_func)
          2'd0:    bus.mem_data_out <= mem_store[p_addr[7:0]];
          2'd1:    mem_store[p_addr[7:0]] <= p_data;
          2'd2: begin
            bus.mem_addr_out <= free_ptr;
            free_ptr         <= free_ptr + 16'd1;
          end
          default: ;
        endcase
        busy             <= 0;
        bus.mem_is_ready <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
    logic              chk_addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rsp_cnt  = 0;
  int   ex_hi    = 0;

  function automatic exp_t mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic e, input logic c);
    exp_t r;
    r.addr = a; r.data = d; r.err = e; r.chk_addr = c;
    return r;
  endfunction

  // Response monitor: every rsp_valid cycle must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.mem_execute === 1'b1) ex_hi++;
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got addr=%h data=%h err=%b, required no response",
                 bus.rsp_addr, bus.rsp_data, bus.rsp_error);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_data !== e.data || bus.rsp_error !== e.err ||
            (e.chk_addr && bus.rsp_addr !== e.addr)) begin
          n_fail++;
          $display("FAIL rsp_scoreboard: got addr=%h data=%h err=%b, required addr=%h data=%h err=%b",
                   bus.rsp_addr, bus.rsp_data, bus.rsp_error, e.addr, e.data, e.err);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    ok = (bus.cmd_ready === 1'b1);
    if (ok) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int target, output bit ok);
    int n = 0;
    while (rsp_cnt < target && n < 200) begin @(negedge clk); n++; end
    ok = (rsp_cnt >= target);
  endtask

  task automatic test_reset;
    bit seen_mem_ready = 1'b0;
    bit early = 1'b0;
    int n = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_addr, bus.rsp_data, bus.rsp_error,
         bus.mem_execute, bus.mem_func, bus.mem_addr_in, bus.mem_data_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd_ready=%b rsp_valid=%b execute=%b func=%h, required all zero",
               bus.cmd_ready, bus.rsp_valid, bus.mem_execute, bus.mem_func);
    end
    rst = 1'b0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
      if (bus.cmd_ready === 1'b1 && !seen_mem_ready) early = 1'b1;
      if (bus.mem_is_ready === 1'b1) seen_mem_ready = 1'b1;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL boot_ready: got cmd_ready=%b, required 1", bus.cmd_ready);
    end
    n_checks++;
    if (early) begin
      n_fail++; $display("FAIL boot_order: got cmd_ready before mem_is_ready, required after");
    end
  endtask

  task automatic test_write_read;
    bit ok;
    int ex0 = ex_hi;
    int n = 0;
    int ready_n = -1;
    int rsp_n = -1;
    exp_q.push_back(mk(16'h0020, 16'h0000, 1'b0, 1'b1));
    send(2'd1, 16'h0020, 16'hABCD, ok);
    wait_rsp(rsp_cnt + 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write_rsp: got no response, required one"); end
    exp_q.push_back(mk(16'h0020, 16'hABCD, 1'b0, 1'b1));
    send(2'd0, 16'h0020, 16'h0000, ok);
    while (rsp_n < 0 && n < 100) begin
      @(negedge clk); n++;
      if (ready_n < 0 && bus.mem_is_ready === 1'b1) ready_n = n;
      if (bus.rsp_valid === 1'b1) rsp_n = n;
    end
    n_checks++;
    if (rsp_n < 0 || rsp_n != ready_n + 1) begin
      n_fail++; $display("FAIL read_latency: got rsp at %0d, required %0d", rsp_n, ready_n + 1);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rsp_pulse: got rsp_valid=%b cmd_ready=%b, required 0 1",
                         bus.rsp_valid, bus.cmd_ready);
    end
    n_checks++;
    if (ex_hi - ex0 != 2) begin
      n_fail++; $display("FAIL wr_execute_cycles: got %0d, required 2", ex_hi - ex0);
    end
  endtask

  task automatic test_cons;
    bit ok;
    int ex0 = ex_hi;
    int base = rsp_cnt;
    exp_q.push_back(mk(16'h0010, 16'h0000, 1'b0, 1'b1));
    send(2'd2, 16'h0000, 16'h1234, ok);
    wait_rsp(base + 1, ok);
    exp_q.push_back(mk(16'h0011, 16'h0000, 1'b0, 1'b1));
    send(2'd2, 16'h0000, 16'h1234, ok);
    wait_rsp(base + 2, ok);
    exp_q.push_back(mk(16'h0010, 16'h1234, 1'b0, 1'b1));
    send(2'd0, 16'h0010, 16'h0000, ok);
    wait_rsp(base + 3, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cons_rsp: got %0d responses, required 3", rsp_cnt - base); end
    n_checks++;
    if (ex_hi - ex0 != 5) begin
      n_fail++; $display("FAIL cons_execute_cycles: got %0d, required 5", ex_hi - ex0);
    end
  endtask

  task automatic test_reserved;
    bit ok;
    int ex0 = ex_hi;
    exp_q.push_back(mk(16'h0055, 16'h0000, 1'b1, 1'b0));
    send(2'd3, 16'h0055, 16'h7777, ok);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reserved_rsp: got valid=%b err=%b cmd_ready=%b, required 1 1 0",
                         bus.rsp_valid, bus.rsp_error, bus.cmd_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ex_hi - ex0 != 0) begin
      n_fail++; $display("FAIL reserved_execute: got %0d, required 0", ex_hi - ex0);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    bit bad = 1'b0;
    int n = 0;
    stuck = 1'b1;
    exp_q.push_back(mk(16'h0020, 16'h0000, 1'b1, 1'b1));
    send(2'd0, 16'h0020, 16'h0000, ok);
    while (bus.rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (n != TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d, required %0d", n, TIMEOUT + 1);
    end
    repeat (10) begin @(negedge clk); if (bus.cmd_ready !== 1'b0) bad = 1'b1; end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL resync_hold: got cmd_ready=1 while memory busy, required 0"); end
    stuck = 1'b0;
    exp_q.push_back(mk(16'h0030, 16'h0000, 1'b0, 1'b1));
    send(2'd1, 16'h0030, 16'h5A5A, ok);
    n_checks++;
    if (!ok || bus.rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL resync_accept: got ok=%b rsp_error=%b, required 1 0", ok, bus.rsp_error);
    end
    wait_rsp(rsp_cnt + 1, ok);
  endtask

  task automatic test_power_reset;
    bit ok;
    bit bad = 1'b0;
    int base = rsp_cnt;
    exp_q.push_back(mk(16'h0020, 16'hABCD, 1'b0, 1'b1));
    send(2'd0, 16'h0020, 16'h0000, ok);
    @(negedge clk);
    power = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.mem_execute !== 1'b0 || bus.cmd_ready !== 1'b0 ||
          bus.mem_addr_in !== 16'h0020 || bus.mem_func !== 2'd0) bad = 1'b1;
    end
    power = 1'b1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL power_freeze: got output change while power=0, required none"); end
    wait_rsp(base + 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL power_resume: got no response, required one"); end

    base = rsp_cnt;
    send(2'd2, 16'h0000, 16'h9999, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_addr, bus.rsp_data, bus.rsp_error,
         bus.mem_execute, bus.mem_func, bus.mem_addr_in, bus.mem_data_in} !== '0) begin
      n_fail++; $display("FAIL midop_reset: got func=%h addr_in=%h data_in=%h, required all zero",
                         bus.mem_func, bus.mem_addr_in, bus.mem_data_in);
    end
    rst = 1'b0;
    exp_q.push_back(mk(16'h0011, 16'h1234, 1'b0, 1'b1));
    send(2'd0, 16'h0011, 16'h0000, ok);
    n_checks++;
    if (rsp_cnt != base) begin
      n_fail++; $display("FAIL reset_no_rsp: got %0d responses, required 0", rsp_cnt - base);
    end
    wait_rsp(base + 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL post_reset_read: got no response, required one"); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    test_reset();
    test_write_read();
    test_cons();
    test_reserved();
    test_timeout();
    test_power_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
